// File: rtl/cas_fsk_player_if.sv
// Symbol feed handshake between the CAS loader and the FSK tape player.
interface cas_fsk_player_if;
  logic       in_valid;
  logic       in_sync;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_sync,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_sync,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/cas_fsk_player.sv
// Cassette transmitter: CAS bytes and sync tones to the MSX 1200-baud FSK tape level.
// Bit 0 = one 1200 Hz cycle, bit 1 = two 2400 Hz cycles; byte = start(0) + 8 LSB-first + 2 stop(1).
module cas_fsk_player #(
  parameter int unsigned HALF_1     = 746,
  parameter int unsigned HALF_0     = 1492,
  parameter int unsigned SYNC_LONG  = 16000,
  parameter int unsigned SYNC_SHORT = 4000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic            motor,
  cas_fsk_player_if.slave feed,
  output logic            busy,
  output logic            cas_audio
);

  localparam int unsigned HpW      = $clog2(HALF_0 + 1);
  localparam int unsigned SyncMax  = (SYNC_LONG > SYNC_SHORT) ? SYNC_LONG : SYNC_SHORT;
  localparam int unsigned SyncBits = $clog2(SyncMax + 1);
  localparam int unsigned SyncW    = (SyncBits > 14) ? SyncBits : 14;

  localparam logic [HpW-1:0]   Half1     = HpW'(HALF_1);
  localparam logic [HpW-1:0]   Half0     = HpW'(HALF_0);
  localparam logic [HpW-1:0]   HpLast    = HpW'(1);
  localparam logic [SyncW-1:0] SyncLong  = SyncW'(SYNC_LONG);
  localparam logic [SyncW-1:0] SyncShort = SyncW'(SYNC_SHORT);
  localparam logic [SyncW-1:0] SyncLast  = SyncW'(1);

  typedef enum logic [2:0] {StIdle, StSync, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [HpW-1:0]   hp_q, hp_d;        // ticks left in current half-period
  logic             phase_q, phase_d;
  logic [1:0]       half_q, half_d;    // half-periods done in current cell / sync cycle
  logic [2:0]       bit_q, bit_d;      // data bit index, or stop cell index
  logic [7:0]       shift_q, shift_d;
  logic [SyncW-1:0] sync_q, sync_d;    // sync cycles left, including current

  logic tick;
  logic cell_one;
  logic cell_end;

  assign tick = ce & motor;

  // Current cell is a 2400 Hz (bit 1) cell; sync tone counts as one.
  always_comb begin
    cell_one = 1'b0;
    unique case (state_q)
      StSync, StStop: cell_one = 1'b1;
      StData:         cell_one = shift_q[0];
      default:        cell_one = 1'b0;
    endcase
    // Sync ends its unit after one cycle; bit-1 cells need two cycles.
    if (cell_one && state_q != StSync) cell_end = (half_q == 2'd3);
    else                                cell_end = (half_q == 2'd1);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hp_q    <= '0;
      phase_q <= 1'b0;
      half_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sync_q  <= sync_d;
    end
  end

  // Next-state: accept in IDLE, otherwise advance only on ticks (motor off freezes everything).
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    phase_d = phase_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sync_d  = sync_q;
    unique case (state_q)
      StIdle: begin
        if (feed.in_valid) begin
          phase_d = 1'b1;
          half_d  = '0;
          bit_d   = '0;
          if (feed.in_sync) begin
            state_d = StSync;
            hp_d    = Half1;
            sync_d  = feed.in_data[0] ? SyncLong : SyncShort;
          end else begin
            state_d = StStart;
            hp_d    = Half0;
            shift_d = feed.in_data;
          end
        end
      end
      default: begin
        if (tick) begin
          if (hp_q != HpLast) begin
            hp_d = hp_q - 1'b1;
          end else begin
            phase_d = ~phase_q;
            half_d  = half_q + 2'd1;
            hp_d    = cell_one ? Half1 : Half0;
            if (cell_end) begin
              // Every cell has an even number of halves, so phase is back to 1 here.
              half_d = '0;
              unique case (state_q)
                StSync: begin
                  if (sync_q == SyncLast) state_d = StIdle;
                  else                    sync_d  = sync_q - 1'b1;
                end
                StStart: begin
                  state_d = StData;
                  bit_d   = '0;
                  hp_d    = shift_q[0] ? Half1 : Half0;
                end
                StData: begin
                  shift_d = shift_q >> 1;
                  if (bit_q == 3'd7) begin
                    state_d = StStop;
                    bit_d   = '0;
                    hp_d    = Half1;
                  end else begin
                    bit_d = bit_q + 3'd1;
                    hp_d  = shift_q[1] ? Half1 : Half0;
                  end
                end
                StStop: begin
                  if (bit_q == 3'd1) begin
                    state_d = StIdle;
                  end else begin
                    bit_d = 3'd1;
                    hp_d  = Half1;
                  end
                end
                default: state_d = StIdle;
              endcase
              if (state_d == StIdle) begin
                hp_d    = '0;
                phase_d = 1'b0;
              end
            end
          end
        end
      end
    endcase
  end

  // Outputs: level is gated by motor so a stopped deck is silent.
  always_comb begin
    feed.in_ready = (state_q == StIdle);
    busy          = (state_q != StIdle);
    cas_audio     = phase_q & motor & (state_q != StIdle);
  end

endmodule
